crossbar1x4_ctrl: RTL and testbench
===================================

Name: crossbar1x4_ctrl

Overview:
Packet-level scheduler for the 1-to-4 crossbar output stage. Accepts a valid/ready input stream, latches each packet's destination on its first beat, and holds the select stable until the packet's last beat. Registers data and select for the crossbar. Uses per-output credit counters to throttle the input, so that a downstream buffer can never overflow.

Parameters:
WIDTH, 320, data beat width in bits; matches the crossbar data width.
CREDITS, 4, initial and maximum credit count per output port (number of beat slots in each downstream buffer); legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  input beat valid
in_ready  output  1  controller accepts the beat this cycle
in_data  input  WIDTH  input beat payload
in_dest  input  2  destination port (0..3); sampled only on a packet's first beat
in_last  input  1  final beat of the packet
xb_data  output  WIDTH  registered data driven to the crossbar input
xb_sel  output  2  registered crossbar select
xb_valid  output  4  one-hot registered beat-valid per output port
credit_ret  input  4  per-port credit return pulse; one credit per asserted bit per cycle
busy  output  1  high while a multi-beat packet is locked
cred_err  output  1  sticky flag: a credit was returned to a port that was already at CREDITS

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all credit counters=CREDITS; xb_data=0; xb_sel=0; xb_valid=0; busy=0; cred_err=0. in_ready=0 while reset is asserted.
- Counters are 4 bits wide. credit[p] is the current credit count for port p.
- Target port: tgt = in_dest in IDLE; tgt = the locked dest (cur) in PKT.
- in_ready = (credit[tgt] != 0). It is combinational from state, cur, in_dest and the credit counters. It must not depend on in_valid.
- Accept: a beat is accepted when in_valid && in_ready.
- On accept, on the next edge: xb_data<=in_data, xb_sel<=tgt, xb_valid<=one-hot(tgt). The latency from input to crossbar is 1 cycle.
- When no beat is accepted in a cycle: xb_valid<=0 on the next edge. xb_sel and xb_data hold their last values.
- States:
  - IDLE: accept with in_last=1 → stay in IDLE (single-beat packet). Accept with in_last=0 → cur<=in_dest, go to PKT, busy<=1.
  - PKT: in_dest is ignored. Accept with in_last=1 → go to IDLE, busy<=0. Any other accept → stay in PKT.
  - When credit[cur]=0, the packet stalls in PKT and does not release the lock.
- Credits, per port p, each cycle:
  - dec = accept && tgt==p; inc = credit_ret[p].
  - dec && inc → no change.
  - dec only → credit[p] − 1.
  - inc only → if credit[p]==CREDITS, the count is unchanged and cred_err<=1; otherwise credit[p] + 1.
  - A decrement at 0 cannot occur, because in_ready is gated.
- Credits for all four ports update independently in the same cycle.
- A return in cycle N makes in_ready high in cycle N+1 at the earliest. There is no combinational bypass from credit_ret to in_ready.
- cred_err is cleared only by reset.
- Reset mid-packet: the partial packet is abandoned. The next accepted beat after reset is treated as a first beat.

Optional Feature:
- Macro XBAR_CTRL_STATS_EN.
- When defined, the block adds:
  - output pkt_cnt0..pkt_cnt3, 16 bits each: count of completed packets per port, incremented on an accepted beat with in_last=1.
  - output stall_cnt, 16 bits: count of cycles with in_valid=1 && in_ready=0.
- All counters wrap from 0xFFFF to 0 and reset to 0.
- When undefined, these ports and registers are absent and the rest of the behaviour is identical.

Test Plan:
- Single-beat packets to dest 0,1,2,3 on consecutive cycles, credit_ret=0 → xb_valid = 0001, 0010, 0100, 1000 one cycle after each accept; xb_data matches each input; credits end at CREDITS−1 per port.
- 3-beat packet, dest=2, with in_dest changed to 1 on beats 2–3 → all three beats appear with xb_sel=2; busy is high from the cycle after beat 1 until the cycle after beat 3.
- CREDITS=4: five back-to-back beats to port 1, no returns → 4 accepted, in_ready=0 on the fifth. Pulse credit_ret[1] → in_ready=1 the next cycle and the fifth beat is accepted.
- Port 3 at credit 0, accept and credit_ret[3] in the same cycle (after one prior return) → credit unchanged. Returning a credit at CREDITS → cred_err=1 and stays 1.
- Assert rst=0 asynchronously during beat 2 of a 4-beat packet → xb_valid=0, busy=0 immediately, credits=CREDITS. After release, a beat with in_dest=0, in_last=1 routes to port 0.
- With XBAR_CTRL_STATS_EN: 2 packets to port 0, 1 packet to port 2, and 3 stall cycles → pkt_cnt0=2, pkt_cnt2=1, stall_cnt=3.

Source files
------------

// File: rtl/crossbar1x4_ctrl.sv
// Packet scheduler for the 1-to-4 crossbar output stage with per-port credit flow control.
// Define XBAR_CTRL_STATS_EN to add per-port packet counters and an input stall counter.
module crossbar1x4_ctrl #(
    parameter int WIDTH   = 320,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_last,
    output logic [WIDTH-1:0] xb_data,
    output logic [1:0]       xb_sel,
    output logic [3:0]       xb_valid,
    input  logic [3:0]       credit_ret,
    output logic             busy,
    output logic             cred_err
`ifdef XBAR_CTRL_STATS_EN
    ,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1,
    output logic [15:0]      pkt_cnt2,
    output logic [15:0]      pkt_cnt3,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cur;
    logic [1:0]      tgt;
    logic            accept;
    logic [3:0][3:0] credit;
    logic [3:0][3:0] credit_nxt;
    logic            err_set;

    // Once a packet is locked, in_dest is ignored until its last beat.
    assign tgt      = (state == PKT) ? cur : in_dest;
    assign in_ready = rst && (credit[tgt] != 4'd0);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == PKT);

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (!in_last) state_nxt = PKT;
                PKT:     if (in_last)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cur   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) cur <= in_dest;
        end
    end

    // A simultaneous take and return cancel out; a return at full credit is flagged, not counted.
    always_comb begin
        err_set    = 1'b0;
        credit_nxt = credit;
        for (int p = 0; p < 4; p++) begin
            if (accept && (tgt == 2'(p)) && !credit_ret[p]) begin
                credit_nxt[p] = credit[p] - 4'd1;
            end else if (!(accept && (tgt == 2'(p))) && credit_ret[p]) begin
                if (credit[p] == CRED_MAX) err_set = 1'b1;
                else                       credit_nxt[p] = credit[p] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit   <= {4{CRED_MAX}};
            cred_err <= 1'b0;
        end else begin
            credit <= credit_nxt;
            if (err_set) cred_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xb_data  <= '0;
            xb_sel   <= 2'd0;
            xb_valid <= 4'd0;
        end else begin
            xb_valid <= 4'd0;
            if (accept) begin
                xb_data  <= in_data;
                xb_sel   <= tgt;
                xb_valid <= 4'b0001 << tgt;
            end
        end
    end

`ifdef XBAR_CTRL_STATS_EN
    logic [3:0][15:0] pkt_cnt;
    logic [15:0]      stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt <= '0;
            stall_q <= 16'd0;
        end else begin
            if (accept && in_last) pkt_cnt[tgt] <= pkt_cnt[tgt] + 16'd1;
            if (in_valid && !in_ready) stall_q <= stall_q + 16'd1;
        end
    end

    assign pkt_cnt0  = pkt_cnt[0];
    assign pkt_cnt1  = pkt_cnt[1];
    assign pkt_cnt2  = pkt_cnt[2];
    assign pkt_cnt3  = pkt_cnt[3];
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_crossbar1x4_ctrl.sv
// Self-checking bench for crossbar1x4_ctrl: reference model + scoreboard plus scenario tasks.
module tb_crossbar1x4_ctrl;

    localparam int WIDTH   = 320;
    localparam int CREDITS = 4;

    typedef struct {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_dest = 2'd0;
    logic             in_last = 1'b0;
    logic [WIDTH-1:0] xb_data;
    logic [1:0]       xb_sel;
    logic [3:0]       xb_valid;
    logic [3:0]       credit_ret = 4'd0;
    logic             busy;
    logic             cred_err;
`ifdef XBAR_CTRL_STATS_EN
    logic [15:0]      pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3, stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    crossbar1x4_ctrl #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_last    (in_last),
        .xb_data    (xb_data),
        .xb_sel     (xb_sel),
        .xb_valid   (xb_valid),
        .credit_ret (credit_ret),
        .busy       (busy),
        .cred_err   (cred_err)
`ifdef XBAR_CTRL_STATS_EN
        ,
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1),
        .pkt_cnt2   (pkt_cnt2),
        .pkt_cnt3   (pkt_cnt3),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: credits, packet lock and expected crossbar beats.
    int         m_cred [4] = '{CREDITS, CREDITS, CREDITS, CREDITS};
    bit         m_locked = 1'b0;
    logic [1:0] m_cur = 2'd0;
    logic [1:0] m_t;
    bit         m_acc;
    bit         m_dec;
    bit         m_err = 1'b0;
    logic [3:0] m_xbv = 4'd0;
    exp_t       m_last = '{2'd0, '0};
    exp_t       m_push;
    exp_t       sb [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++) m_cred[p] = CREDITS;
            m_locked = 1'b0;
            m_cur    = 2'd0;
            m_err    = 1'b0;
            m_xbv    = 4'd0;
            m_last   = '{2'd0, '0};
            sb.delete();
        end else begin
            m_t   = m_locked ? m_cur : in_dest;
            m_acc = in_valid && (m_cred[m_t] != 0);
            if (m_acc) begin
                m_push.sel  = m_t;
                m_push.data = in_data;
                sb.push_back(m_push);
                m_xbv = 4'b0001 << m_t;
            end else begin
                m_xbv = 4'd0;
            end
            for (int p = 0; p < 4; p++) begin
                m_dec = m_acc && (m_t == 2'(p));
                if (m_dec && !credit_ret[p]) m_cred[p] = m_cred[p] - 1;
                else if (!m_dec && credit_ret[p]) begin
                    if (m_cred[p] == CREDITS) m_err = 1'b1;
                    else m_cred[p] = m_cred[p] + 1;
                end
            end
            if (m_acc) begin
                if (!m_locked && !in_last) begin
                    m_locked = 1'b1;
                    m_cur    = in_dest;
                end else if (m_locked && in_last) begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    logic exp_ready;
    exp_t e;

    always @(negedge clk) begin
        exp_ready = rst && (m_cred[m_locked ? m_cur : in_dest] != 0);
        checks++;
        if (in_ready !== exp_ready) begin
            failures++;
            $display("[TB] FAIL mon_in_ready got=%b exp=%b t=%0t", in_ready, exp_ready, $time);
        end
        checks++;
        if (xb_valid !== m_xbv) begin
            failures++;
            $display("[TB] FAIL mon_xb_valid got=%b exp=%b t=%0t", xb_valid, m_xbv, $time);
        end
        if (m_xbv != 4'd0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL mon_scoreboard_empty got=0 exp=1 t=%0t", $time);
            end else begin
                e = sb.pop_front();
                m_last = e;
            end
        end
        checks++;
        if (xb_sel !== m_last.sel) begin
            failures++;
            $display("[TB] FAIL mon_xb_sel got=%0d exp=%0d t=%0t", xb_sel, m_last.sel, $time);
        end
        checks++;
        if (xb_data !== m_last.data) begin
            failures++;
            $display("[TB] FAIL mon_xb_data got=%h exp=%h", xb_data, m_last.data);
        end
        checks++;
        if (busy !== m_locked) begin
            failures++;
            $display("[TB] FAIL mon_busy got=%b exp=%b t=%0t", busy, m_locked, $time);
        end
        checks++;
        if (cred_err !== m_err) begin
            failures++;
            $display("[TB] FAIL mon_cred_err got=%b exp=%b t=%0t", cred_err, m_err, $time);
        end
    end

    function automatic logic [WIDTH-1:0] rand_data();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic set_inputs(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] dst,
                              input logic l, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_data    = d;
        in_dest    = dst;
        in_last    = l;
        credit_ret = r;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_dest  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (xb_valid !== 4'd0) begin failures++; $display("[TB] FAIL reset_xb_valid got=%b exp=0", xb_valid); end
        checks++;
        if (xb_sel !== 2'd0) begin failures++; $display("[TB] FAIL reset_xb_sel got=%0d exp=0", xb_sel); end
        checks++;
        if (xb_data !== '0) begin failures++; $display("[TB] FAIL reset_xb_data got=%h exp=0", xb_data); end
        checks++;
        if (busy !== 1'b0 || cred_err !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_flags got=%b%b exp=00", busy, cred_err);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_beats();
        logic [WIDTH-1:0] d [4];
        logic [3:0]       exp_v;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                d[i] = rand_data();
                set_inputs(1'b1, d[i], 2'(i), 1'b1, 4'd0);
            end else begin
                set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
            end
            if (i > 0) begin
                exp_v = 4'b0001 << (i - 1);
                checks++;
                if (xb_valid !== exp_v || xb_data !== d[i-1]) begin
                    failures++;
                    $display("[TB] FAIL single_beat%0d got=%b exp=%b", i - 1, xb_valid, exp_v);
                end
            end
        end
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b1111);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic test_multibeat();
        logic [WIDTH-1:0] d1, d2, d3;
        d1 = rand_data();
        d2 = rand_data();
        d3 = rand_data();
        set_inputs(1'b1, d1, 2'd2, 1'b0, 4'd0);
        set_inputs(1'b1, d2, 2'd1, 1'b0, 4'd0);
        checks++;
        if (xb_sel !== 2'd2 || xb_data !== d1 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL multi_beat1 got=sel%0d busy%b exp=sel2 busy1", xb_sel, busy);
        end
        set_inputs(1'b1, d3, 2'd1, 1'b1, 4'd0);
        checks++;
        if (xb_sel !== 2'd2 || xb_data !== d2 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL multi_beat2 got=sel%0d busy%b exp=sel2 busy1", xb_sel, busy);
        end
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
        checks++;
        if (xb_sel !== 2'd2 || xb_data !== d3 || busy !== 1'b0 || xb_valid !== 4'b0100) begin
            failures++; $display("[TB] FAIL multi_beat3 got=sel%0d busy%b exp=sel2 busy0", xb_sel, busy);
        end
        repeat (3) set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b0100);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic test_credit_stall();
        logic [WIDTH-1:0] d [5];
        for (int i = 0; i < 5; i++) begin
            d[i] = rand_data();
            set_inputs(1'b1, d[i], 2'd1, 1'b1, 4'd0);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_fifth_ready got=%b exp=0", in_ready); end
        set_inputs(1'b1, d[4], 2'd1, 1'b1, 4'b0010);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_no_bypass got=%b exp=0", in_ready); end
        set_inputs(1'b1, d[4], 2'd1, 1'b1, 4'd0);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_return_ready got=%b exp=1", in_ready); end
        set_inputs(1'b0, '0, 2'd1, 1'b0, 4'd0);
        checks++;
        if (xb_valid !== 4'b0010 || xb_data !== d[4]) begin
            failures++; $display("[TB] FAIL stall_fifth_out got=%b exp=0010", xb_valid);
        end
        repeat (4) set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b0010);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic test_credit_simul();
        for (int i = 0; i < 4; i++) set_inputs(1'b1, rand_data(), 2'd3, 1'b1, 4'd0);
        set_inputs(1'b0, '0, 2'd3, 1'b1, 4'b1000);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL simul_empty_ready got=%b exp=0", in_ready); end
        set_inputs(1'b1, rand_data(), 2'd3, 1'b1, 4'b1000);
        set_inputs(1'b0, '0, 2'd3, 1'b1, 4'd0);
        checks++;
        if (in_ready !== 1'b1 || xb_valid !== 4'b1000) begin
            failures++; $display("[TB] FAIL simul_unchanged got=%b exp=1", in_ready);
        end
        set_inputs(1'b1, rand_data(), 2'd3, 1'b1, 4'd0);
        set_inputs(1'b0, '0, 2'd3, 1'b1, 4'd0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL simul_drained got=%b exp=0", in_ready); end
        repeat (4) set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b1000);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
        checks++;
        if (cred_err !== 1'b0) begin failures++; $display("[TB] FAIL err_before got=%b exp=0", cred_err); end
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b1000);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
        checks++;
        if (cred_err !== 1'b1) begin failures++; $display("[TB] FAIL err_set got=%b exp=1", cred_err); end
        repeat (3) set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
        checks++;
        if (cred_err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky got=%b exp=1", cred_err); end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d3;
        set_inputs(1'b1, rand_data(), 2'd0, 1'b0, 4'd0);
        set_inputs(1'b1, rand_data(), 2'd0, 1'b0, 4'd0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (xb_valid !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b0 || cred_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async got=v%b b%b r%b e%b exp=v0000 b0 r0 e0", xb_valid, busy, in_ready, cred_err);
        end
        d3 = rand_data();
        set_inputs(1'b1, d3, 2'd0, 1'b1, 4'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready got=%b exp=1", in_ready); end
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
        checks++;
        if (xb_valid !== 4'b0001 || xb_data !== d3 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_route got=%b exp=0001", xb_valid);
        end
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b0001);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
    endtask

`ifdef XBAR_CTRL_STATS_EN
    task automatic test_stats();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_inputs(1'b1, rand_data(), 2'd0, 1'b1, 4'd0);
        set_inputs(1'b1, rand_data(), 2'd0, 1'b0, 4'd0);
        set_inputs(1'b1, rand_data(), 2'd2, 1'b1, 4'd0);
        set_inputs(1'b1, rand_data(), 2'd2, 1'b0, 4'd0);
        repeat (3) set_inputs(1'b1, rand_data(), 2'd2, 1'b0, 4'd0);
        set_inputs(1'b1, rand_data(), 2'd2, 1'b1, 4'd0);
        set_inputs(1'b1, in_data, 2'd2, 1'b1, 4'd0);
        set_inputs(1'b1, in_data, 2'd2, 1'b1, 4'b0100);
        set_inputs(1'b1, in_data, 2'd2, 1'b1, 4'd0);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
        checks++;
        if (pkt_cnt0 !== 16'd2 || pkt_cnt1 !== 16'd0 || pkt_cnt2 !== 16'd1 || pkt_cnt3 !== 16'd0) begin
            failures++;
            $display("[TB] FAIL stats_pkt got=%0d/%0d/%0d/%0d exp=2/0/1/0", pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3);
        end
        checks++;
        if (stall_cnt !== 16'd3) begin failures++; $display("[TB] FAIL stats_stall got=%0d exp=3", stall_cnt); end
        repeat (3) set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b0101);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'b0100);
        set_inputs(1'b0, '0, 2'd0, 1'b0, 4'd0);
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting crossbar1x4_ctrl bench");
        test_reset();
        test_single_beats();
        test_multibeat();
        test_credit_stall();
        test_credit_simul();
        test_reset_mid();
`ifdef XBAR_CTRL_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
